// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate truth-table sweep controller.
// State encoding, standard 2-input truth tables and a counter-width helper.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

  // Bits needed to hold SETTLE-1; never less than one bit.
  function automatic int cnt_width(input int settle);
    if (settle <= 2) begin
      return 1;
    end else begin
      return $clog2(settle);
    end
  endfunction

endpackage

// File: rtl/gate_sweep_timer.sv
// Settle down-counter: load a start value, count down while enabled,
// and flag zero so the controller knows the vector has settled.
module gate_sweep_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_count;

  // Down-counter register; load takes priority over decrement, stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// On-chip truth-table sweep of a combinational gate with mismatch counting.
// Optional macro GSC_FAIL_CAPTURE_EN adds first-failing-vector capture ports.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter int                    SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = TT_AND2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_out,
`ifdef GSC_FAIL_CAPTURE_EN
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld,
`endif
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count
);

  localparam int            CW   = cnt_width(SETTLE);
  localparam logic [CW-1:0] LOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};

  state_e r_state;
  state_e w_next;

  logic [N_IN-1:0] r_gate_in, w_gate_in_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_pass, w_pass_nxt;
  logic [N_IN:0]   r_err, w_err_nxt, w_err_inc;

  logic w_zero;
  logic w_accept;
  logic w_last;
  logic w_mismatch;
  logic w_load;
  logic w_dec;

  assign w_accept   = start && !abort && (r_state == ST_IDLE);
  assign w_last     = (r_gate_in == LAST);
  // Case inequality so an X/Z gate output is counted as a mismatch in simulation.
  assign w_mismatch = (gate_out !== EXPECT[r_gate_in]);
  assign w_err_inc  = r_err + {{N_IN{1'b0}}, w_mismatch};
  assign w_load     = w_accept || ((r_state == ST_CHECK) && !w_last && !abort);
  assign w_dec      = (r_state == ST_APPLY);

  gate_sweep_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .dec      (w_dec),
    .load_val (LOAD),
    .zero     (w_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = start  ? ST_APPLY : ST_IDLE;
        ST_APPLY: w_next = w_zero ? ST_CHECK : ST_APPLY;
        ST_CHECK: w_next = w_last ? ST_DONE  : ST_APPLY;
        ST_DONE:  w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    w_gate_in_nxt = r_gate_in;
    w_err_nxt     = r_err;
    w_pass_nxt    = r_pass;
    w_done_nxt    = 1'b0;
    w_busy_nxt    = (w_next == ST_APPLY) || (w_next == ST_CHECK);
    if (abort) begin
      w_pass_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_gate_in_nxt = '0;
            w_err_nxt     = '0;
            w_pass_nxt    = 1'b0;
          end else begin
            w_gate_in_nxt = r_gate_in;
          end
        end
        ST_CHECK: begin
          w_err_nxt = w_err_inc;
          if (w_last) begin
            w_done_nxt = 1'b1;
            w_pass_nxt = (w_err_inc == '0);
          end else begin
            w_gate_in_nxt = r_gate_in + N_IN'(1);
          end
        end
        default: begin
          w_gate_in_nxt = r_gate_in;
        end
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_in <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
    end else begin
      r_gate_in <= w_gate_in_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign gate_in   = r_gate_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;

`ifdef GSC_FAIL_CAPTURE_EN
  logic [N_IN-1:0] r_first_fail;
  logic            r_first_fail_vld;

  // First-mismatch capture; cleared by an accepted start, untouched by abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_fail     <= '0;
      r_first_fail_vld <= 1'b0;
    end else if (w_accept) begin
      r_first_fail     <= '0;
      r_first_fail_vld <= 1'b0;
    end else if (!abort && (r_state == ST_CHECK) && w_mismatch && !r_first_fail_vld) begin
      r_first_fail     <= r_gate_in;
      r_first_fail_vld <= 1'b1;
    end else begin
      r_first_fail     <= r_first_fail;
      r_first_fail_vld <= r_first_fail_vld;
    end
  end

  assign first_fail     = r_first_fail;
  assign first_fail_vld = r_first_fail_vld;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench: sweeps queue expected results, done-driven monitors check them.
module tb_gate_sweep_ctrl;

  typedef struct {
    logic [2:0] err;
    logic       pass;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, abort0 = 1'b0;
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [1:0] gate_in0, gate_in1;
  logic       gate_out0, gate_out1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [1:0] mode = 2'd0;
`ifdef GSC_FAIL_CAPTURE_EN
  logic [1:0] ff0, ff1;
  logic       ffv0, ffv1;
`endif

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate models: 0 = AND, 1 = stuck-at-0, 2 = OR.
  always_comb begin
    case (mode)
      2'd0:    gate_out0 = &gate_in0;
      2'd1:    gate_out0 = 1'b0;
      default: gate_out0 = |gate_in0;
    endcase
    gate_out1 = &gate_in1;
  end

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(2), .EXPECT(4'b1000)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .gate_in(gate_in0), .gate_out(gate_out0),
`ifdef GSC_FAIL_CAPTURE_EN
    .first_fail(ff0), .first_fail_vld(ffv0),
`endif
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
  );

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXPECT(4'b1000)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .gate_in(gate_in1), .gate_out(gate_out1),
`ifdef GSC_FAIL_CAPTURE_EN
    .first_fail(ff1), .first_fail_vld(ffv1),
`endif
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [2:0] err, input logic pass);
    exp_t e;
    e.err = err; e.pass = pass; e.cyc = cyc + 13;
    q0.push_back(e);
  endtask

  // Monitors: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        chk("dut0 unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0 err_count", 32'(err0), 32'(e.err));
        chk("dut0 pass", 32'(pass0), 32'(e.pass));
        chk("dut0 latency", 32'(cyc), 32'(e.cyc));
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1 err_count", 32'(err1), 32'(e.err));
        chk("dut1 pass", 32'(pass1), 32'(e.pass));
        chk("dut1 latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    step(3);
    chk("reset gate_in", 32'(gate_in0), 32'd0);
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset done", 32'(done0), 32'd0);
    chk("reset pass", 32'(pass0), 32'd0);
    chk("reset err_count", 32'(err0), 32'd0);
    rst_n = 1'b1;
    step(2);

    // AND sweep with a stray start mid-sweep; check vector stepping.
    mode = 2'd0;
    push0(3'd0, 1'b1);
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("and gate_in step", 32'(gate_in0), 32'(i / 3));
      chk("and busy", 32'(busy0), 32'd1);
      start0 = (i == 4) ? 1'b1 : 1'b0;
      step(1);
    end
    start0 = 1'b0;
    step(1);
    chk("and idle busy", 32'(busy0), 32'd0);
    chk("and idle done", 32'(done0), 32'd0);
    chk("and pass held", 32'(pass0), 32'd1);
    chk("and last gate_in", 32'(gate_in0), 32'd3);

    // Stuck-at-0 gate: only vector 3 mismatches.
    mode = 2'd1;
    push0(3'd1, 1'b0);
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    step(13);
`ifdef GSC_FAIL_CAPTURE_EN
    chk("stuck first_fail", 32'(ff0), 32'd3);
    chk("stuck first_fail_vld", 32'(ffv0), 32'd1);
`endif

    // OR gate vs AND table: vectors 1 and 2 mismatch.
    mode = 2'd2;
    push0(3'd2, 1'b0);
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    step(13);
`ifdef GSC_FAIL_CAPTURE_EN
    chk("or first_fail", 32'(ff0), 32'd1);
`endif

    // Abort during the third vector (vector 1 already counted).
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    step(6);
    chk("pre-abort gate_in", 32'(gate_in0), 32'd2);
    abort0 = 1'b1;
    step(1);
    abort0 = 1'b0;
    chk("abort busy", 32'(busy0), 32'd0);
    chk("abort err_count", 32'(err0), 32'd1);
    chk("abort pass", 32'(pass0), 32'd0);
    step(4);
    chk("abort stays idle", 32'(busy0), 32'd0);
`ifdef GSC_FAIL_CAPTURE_EN
    chk("abort first_fail_vld", 32'(ffv0), 32'd1);
`endif

    // start together with abort in IDLE is refused.
    start0 = 1'b1;
    abort0 = 1'b1;
    step(1);
    start0 = 1'b0;
    abort0 = 1'b0;
    chk("start+abort busy", 32'(busy0), 32'd0);
    chk("start+abort err kept", 32'(err0), 32'd1);
    step(2);

    // Fresh start clears the count and passes.
    mode = 2'd0;
    push0(3'd0, 1'b1);
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    chk("restart err cleared", 32'(err0), 32'd0);
    step(13);

    // Asynchronous reset during CHECK of vector 2.
    mode = 2'd2;
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    step(8);
    chk("pre-reset gate_in", 32'(gate_in0), 32'd2);
    chk("pre-reset err_count", 32'(err0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset gate_in", 32'(gate_in0), 32'd0);
    chk("async reset busy", 32'(busy0), 32'd0);
    chk("async reset done", 32'(done0), 32'd0);
    chk("async reset pass", 32'(pass0), 32'd0);
    chk("async reset err_count", 32'(err0), 32'd0);
`ifdef GSC_FAIL_CAPTURE_EN
    chk("async reset first_fail_vld", 32'(ffv0), 32'd0);
`endif
    #2;
    rst_n = 1'b1;
    step(2);
    mode = 2'd0;
    push0(3'd0, 1'b1);
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    step(14);

    // SETTLE=1 instance: 8-cycle sweep.
    begin
      exp_t e;
      e.err = 3'd0; e.pass = 1'b1; e.cyc = cyc + 9;
      q1.push_back(e);
    end
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    chk("settle1 busy", 32'(busy1), 32'd1);
    step(10);

    chk("dut0 pending expectations", 32'(q0.size()), 32'd0);
    chk("dut1 pending expectations", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
